// File: rtl/instr_queue.sv
// Circular FIFO of decoded instructions between decode and issue dispatch.
// Optional same-cycle empty-queue bypass enabled by `define INSTR_QUEUE_BYPASS_EN.
package instr_queue_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  branch_id;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } instr_struct;
endpackage

module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             load_queue,
  input  instr_struct      instruction_i,
  input  logic             dequeue,
  output instr_struct      instruction_o,
  output logic             valid_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PTR_W:0]   count_o,
  output logic             overflow_o
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  instr_struct      r_mem [DEPTH];
  logic [PTR_W-1:0] r_head, r_tail;
  logic [PTR_W:0]   r_count;
  logic             r_overflow;

  logic w_full, w_empty, w_pop, w_push, w_bypass;

  // Status flags come from registered count only, so decode sees no comb loop.
  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_pop   = dequeue && !w_empty;

`ifdef INSTR_QUEUE_BYPASS_EN
  logic w_consume;
  assign w_bypass  = w_empty && load_queue && !flush_i;
  // A bypassed instruction popped in the same cycle never touches storage.
  assign w_consume = w_bypass && dequeue;
  assign w_push    = load_queue && (!w_full || w_pop) && !w_consume;
`else
  assign w_bypass  = 1'b0;
  assign w_push    = load_queue && (!w_full || w_pop);
`endif

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
      r_overflow <= load_queue && w_full && !w_pop;
    end
  end

  // Storage needs no reset; pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && !flush_i && w_push) r_mem[r_tail] <= instruction_i;
  end

  always_comb begin
    instruction_o = '0;
    if (!w_empty)      instruction_o = r_mem[r_head];
    else if (w_bypass) instruction_o = instruction_i;
  end

  assign valid_o    = !w_empty || w_bypass;
  assign full_o     = w_full;
  assign empty_o    = w_empty;
  assign count_o    = r_count;
  assign overflow_o = r_overflow;

endmodule

// File: tb/tb_instr_queue.sv
// Scoreboard bench for instr_queue: stimulus queues expected pops, a negedge monitor checks them.
module tb_instr_queue;
  import instr_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int PTR_W = $clog2(DEPTH);

  logic           clk = 1'b0;
  logic           rst, flush_i, load_queue, dequeue;
  instr_struct    instruction_i, instruction_o;
  logic           valid_o, full_o, empty_o, overflow_o;
  logic [PTR_W:0] count_o;

  int total = 0;
  int bad   = 0;
  instr_struct exp_q[$];

  instr_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .load_queue(load_queue),
    .instruction_i(instruction_i), .dequeue(dequeue),
    .instruction_o(instruction_o), .valid_o(valid_o), .full_o(full_o),
    .empty_o(empty_o), .count_o(count_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  function automatic instr_struct mk(input logic [31:0] pc);
    instr_struct s;
    s.pc        = pc;
    s.branch_id = pc[5:2] ^ 4'h5;
    s.opcode    = 7'h33;
    s.rd        = pc[6:2];
    s.rs1       = 5'd1;
    s.rs2       = 5'd2;
    s.imm       = ~pc;
    return s;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    load_queue = 1'b0; dequeue = 1'b0; flush_i = 1'b0; instruction_i = '0;
  endtask

  task automatic drive_push(input logic [31:0] pc, input logic deq, input logic accepted);
    load_queue = 1'b1; dequeue = deq; instruction_i = mk(pc);
    if (accepted) exp_q.push_back(mk(pc));
  endtask

  // Monitor: every accepted pop must present the oldest queued instruction.
  always @(negedge clk) begin
    if (!rst && !flush_i && dequeue && valid_o) begin
      if (exp_q.size() == 0) chk("pop_unexpected", 128'(instruction_o.pc), 128'hdead);
      else chk("pop_data", 128'(instruction_o), 128'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    idle_in();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset state held through 5 idle cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_valid", 128'(valid_o), 0);
      chk("rst_empty", 128'(empty_o), 1);
      chk("rst_full",  128'(full_o), 0);
      chk("rst_count", 128'(count_o), 0);
      chk("rst_instr", 128'(instruction_o), 0);
      chk("rst_ovf",   128'(overflow_o), 0);
    end

    // Three pushes then three pops
    for (int i = 0; i < 3; i++) begin
      drive_push(32'h60 + 32'(4*i), 1'b0, 1'b1);
      tick();
      chk("push3_count", 128'(count_o), 128'(i+1));
    end
    chk("push3_head", 128'(instruction_o.pc), 128'h60);
    idle_in();
    for (int i = 0; i < 3; i++) begin
      dequeue = 1'b1;
      tick();
      chk("pop3_count", 128'(count_o), 128'(2-i));
    end
    chk("pop3_empty", 128'(empty_o), 1);
    // Dequeue while empty is ignored
    tick();
    chk("deq_empty_count", 128'(count_o), 0);
    chk("deq_empty_ovf", 128'(overflow_o), 0);
    idle_in();

    // Fill, then overflow
    for (int i = 0; i < DEPTH; i++) begin
      drive_push(32'h80 + 32'(4*i), 1'b0, 1'b1);
      tick();
    end
    chk("fill_full",  128'(full_o), 1);
    chk("fill_count", 128'(count_o), 8);
    drive_push(32'h100, 1'b0, 1'b0);
    tick();
    chk("ovf_pulse", 128'(overflow_o), 1);
    chk("ovf_count", 128'(count_o), 8);
    chk("ovf_head",  128'(instruction_o.pc), 128'h80);
    idle_in();
    tick();
    chk("ovf_clear", 128'(overflow_o), 0);

    // Push+pop on full queue is accepted
    drive_push(32'h200, 1'b1, 1'b1);
    tick();
    chk("fullpp_count", 128'(count_o), 8);
    chk("fullpp_head",  128'(instruction_o.pc), 128'h84);
    chk("fullpp_ovf",   128'(overflow_o), 0);
    idle_in();
    for (int i = 0; i < DEPTH; i++) begin
      dequeue = 1'b1;
      tick();
    end
    chk("drain_empty", 128'(empty_o), 1);
    chk("drain_sb", 128'(exp_q.size()), 0);
    idle_in();

    // Pointer wrap with steady push/pop pairs
    drive_push(32'h400, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 20; i++) begin
      drive_push(32'h404 + 32'(4*i), 1'b1, 1'b1);
      tick();
      chk("wrap_count_le2", 128'(count_o <= 2), 1);
      chk("wrap_count", 128'(count_o), 1);
    end
    idle_in();
    dequeue = 1'b1;
    tick();
    chk("wrap_empty", 128'(empty_o), 1);
    idle_in();

    // Flush overrides same-cycle push and pop
    for (int i = 0; i < 5; i++) begin
      drive_push(32'h500 + 32'(4*i), 1'b0, 1'b1);
      tick();
    end
    chk("preflush_count", 128'(count_o), 5);
    flush_i = 1'b1; load_queue = 1'b1; dequeue = 1'b1; instruction_i = mk(32'h5ff);
    tick();
    exp_q.delete();
    chk("flush_count", 128'(count_o), 0);
    chk("flush_empty", 128'(empty_o), 1);
    chk("flush_valid", 128'(valid_o), 0);
    chk("flush_ovf",   128'(overflow_o), 0);
    idle_in();
    drive_push(32'h300, 1'b0, 1'b1);
    tick();
    idle_in();
    chk("postflush_valid", 128'(valid_o), 1);
    chk("postflush_head",  128'(instruction_o.pc), 128'h300);
    chk("postflush_bid",   128'(instruction_o.branch_id), 128'(4'h0 ^ 4'h5));
    dequeue = 1'b1;
    tick();
    idle_in();
    chk("final_empty", 128'(empty_o), 1);
    chk("final_sb", 128'(exp_q.size()), 0);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
